// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback port arbiter bus: pipeline, long-latency unit and register-file write signals
// slave is the arbiter's view; master is the surrounding pipeline/LU/register-file side.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 pipe_we_in;
  logic [4:0]           pipe_rd_in;
  logic signed [63:0]   pipe_data_in;
  logic                 pipe_stall_out;
  logic                 lu_valid_in;
  logic [4:0]           lu_rd_in;
  logic signed [63:0]   lu_data_in;
  logic                 lu_ready_out;
  logic                 rf_we_out;
  logic [4:0]           rf_waddr_out;
  logic signed [63:0]   rf_wdata_out;
  logic [CW-1:0]        lu_pending_out;

  modport slave (
    input  pipe_we_in, pipe_rd_in, pipe_data_in, lu_valid_in, lu_rd_in, lu_data_in,
    output pipe_stall_out, lu_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out, lu_pending_out
  );

  modport master (
    output pipe_we_in, pipe_rd_in, pipe_data_in, lu_valid_in, lu_rd_in, lu_data_in,
    input  pipe_stall_out, lu_ready_out, rf_we_out, rf_waddr_out, rf_wdata_out, lu_pending_out
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between pipeline writeback and a buffered long-latency unit
// Buffered LU results fill idle slots; a full or starved buffer preempts the pipeline for one cycle per entry.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  wb_port_arbiter_if.slave    bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]         fifo_rd   [DEPTH];
  logic signed [63:0] fifo_data [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [SW-1:0]      starve;

  logic pipe_req;
  logic fifo_req;
  logic full;
  logic starved;
  logic fifo_win;
  logic pipe_win;
  logic push;

  assign pipe_req = bus.pipe_we_in && (bus.pipe_rd_in != 5'd0);
  assign fifo_req = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign starved  = (starve == SW'(STARVE_LIMIT));
  assign fifo_win = fifo_req && (full || starved || !pipe_req);
  assign pipe_win = pipe_req && !fifo_win;

  // x0 results complete the handshake but are never stored.
  assign push = bus.lu_valid_in && !full && (bus.lu_rd_in != 5'd0);

  assign bus.pipe_stall_out = pipe_req && fifo_win;
  assign bus.lu_ready_out   = !full;
  assign bus.lu_pending_out = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lu_rd_in;
      fifo_data[wr_ptr] <= bus.lu_data_in;
    end
  end

  // Full/empty come from count alone, so pointers simply wrap modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (fifo_win)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fifo_win};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve <= '0;
    else if (fifo_win || !fifo_req)
      starve <= '0;
    else if (!starved)
      starve <= starve + SW'(1);
  end

  // Address/data hold their last values on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rf_we_out    <= 1'b0;
      bus.rf_waddr_out <= 5'd0;
      bus.rf_wdata_out <= 64'sd0;
    end else if (fifo_win) begin
      bus.rf_we_out    <= 1'b1;
      bus.rf_waddr_out <= fifo_rd[rd_ptr];
      bus.rf_wdata_out <= fifo_data[rd_ptr];
    end else if (pipe_win) begin
      bus.rf_we_out    <= 1'b1;
      bus.rf_waddr_out <= bus.pipe_rd_in;
      bus.rf_wdata_out <= bus.pipe_data_in;
    end else begin
      bus.rf_we_out    <= 1'b0;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback (stage-5 output) and a long-latency execution unit (multiplier/divider). Long-latency results are buffered in a small FIFO and inserted into free writeback slots. When a buffered result has waited too long or the buffer is full, the block takes the port and stalls the pipeline writeback. Register-file write outputs are registered, and x0 writes are filtered.

## Interface
Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before it preempts the pipeline (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pipe_we_in  in  1  pipeline writeback request (stage-5 RegWrite)
- pipe_rd_in  in  5  pipeline destination register
- pipe_data_in  in  64 signed  pipeline writeback data
- pipe_stall_out  out  1  combinational; pipeline must hold its stage-5 inputs this cycle
- lu_valid_in  in  1  long-latency result valid
- lu_rd_in  in  5  long-latency destination register
- lu_data_in  in  64 signed  long-latency result
- lu_ready_out  out  1  FIFO can accept (count < DEPTH), from registered count
- rf_we_out  out  1  register-file write enable, registered
- rf_waddr_out  out  5  register-file write address, registered
- rf_wdata_out  out  64 signed  register-file write data, registered
- lu_pending_out  out  $clog2(DEPTH)+1  current FIFO occupancy, registered

## Operation
- **LU push:** occurs when lu_valid_in && lu_ready_out. If lu_rd_in==0, the handshake completes but nothing is stored.
- **Pipe request:** a request exists only when pipe_we_in && pipe_rd_in!=0. A pipe request with rd==0 is neither granted nor stalled.
- **FIFO request:** exists when count>0. The head is the oldest entry.
- **Grant rule, evaluated each cycle:**
  - FIFO wins if it has a request and either count==DEPTH, starve==STARVE_LIMIT, or there is no pipe request.
  - Otherwise the pipe wins if it has a request.
  - Otherwise there is no grant.
- **pipe_stall_out** = pipe request && FIFO wins. While stalled, the pipeline re-presents the same rd/data next cycle.
- **FIFO pop** happens on a FIFO grant. Pop and push in the same cycle are allowed. Count is updated as count + push − pop.
- **Starve counter** (0..STARVE_LIMIT, saturating):
  - Cleared when the FIFO is granted or the FIFO is empty.
  - Otherwise incremented while the FIFO is non-empty and not granted.
- **Outputs on the next edge:**
  - Any grant: rf_we_out←1, and addr/data take the winner's values.
  - No grant: rf_we_out←0, and addr/data hold their previous values.
- WAW ordering between the sources is guaranteed by issue logic. The block does not compare rd values.

## Timing
- **Reset values:** rf_we_out=0, rf_waddr_out=0, rf_wdata_out=0, count/lu_pending_out=0, starve=0, FIFO pointers=0. This gives lu_ready_out=1 and pipe_stall_out=0.
- **Reset mid-operation:** buffered LU results are discarded. The LU issuer must flush as well.
- **Pipe latency:** request in cycle N → rf_we_out high in cycle N+1 (when granted in N).
- **LU latency:** accepted in N → earliest grant in N+1 → rf write visible in N+2.
- **Full FIFO:** lu_ready_out=0 for the whole cycle. A pop in that cycle does not raise ready until the next cycle (no same-cycle pass-through).
- **Bounded stall:** pipe_stall_out is asserted for at most one consecutive cycle per FIFO entry granted. After the pipe is stalled, the starve reset lets the pipe win the following cycle unless count==DEPTH.
- **Pointer wrap:** pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer compare.

## Test plan
- **Reset/idle:** assert reset mid-run with 2 entries buffered → all outputs go to reset values immediately. After release, lu_ready_out=1 and lu_pending_out=0.
- **Pipe only:** pipe_we_in=1, rd=5, data=-7 in cycle N → rf_we_out=1, waddr=5, wdata=-7 in N+1. Next cycle rd=0 → rf_we_out=0, addr/data held, no stall.
- **LU into idle slot:** lu_valid_in with rd=9, data=0x1234 and no pipe request → lu_pending_out=1 next cycle → rf write of x9=0x1234 two cycles after acceptance.
- **Starvation:**
  - Stimulus: continuous pipe writes (rd=1..), one LU entry (rd=12) accepted in cycle 0, STARVE_LIMIT=4.
  - Starve reaches 4 at cycle 5 → pipe_stall_out=1 in cycle 5 → x12 written at cycle 6.
  - The held pipe write is granted in cycle 6, writes at cycle 7, and nothing is lost or duplicated.
- **Full FIFO:**
  - Stimulus: continuous pipe writes; push 2 LU results in back-to-back cycles.
  - count==2 → lu_ready_out=0 and the FIFO preempts immediately (stall). Third lu_valid_in is held until ready returns.
  - Register-file writes follow FIFO order.
- **x0 filter:** LU push with rd=0 → handshake completes, lu_pending_out unchanged, no rf write ever occurs.
